// File: rtl/hex_display_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : hex_display_scheduler
// Brief    : Time-shares the 16-digit hex display among debug sources.
// Revision : 1.0 - initial release
// ============================================================================
module hex_display_scheduler #(
  parameter int          N_SRC        = 4,
  parameter int          IDXW         = 2,
  parameter int          DWELL        = 27000000,
  parameter int          ALERT_HOLD   = 54000000,
  parameter logic [63:0] IDLE_PATTERN = 64'h0
) (
  input  logic                  clock_27mhz,
  input  logic                  reset_b,
  input  logic [N_SRC-1:0]      src_valid,
  input  logic [64*N_SRC-1:0]   src_data,
  input  logic [N_SRC-1:0]      alert,
  input  logic                  auto_mode,
  input  logic                  next_pulse,
  output logic [63:0]           disp_data,
  output logic [IDXW-1:0]       disp_src,
  output logic                  disp_active,
  output logic                  alert_active,
  output logic                  switch_strobe
);

  localparam logic [1:0]  c_st_idle   = 2'd0;
  localparam logic [1:0]  c_st_show   = 2'd1;
  localparam logic [1:0]  c_st_alert  = 2'd2;
  localparam logic [31:0] c_dwell_last = 32'(DWELL - 1);
  localparam logic [31:0] c_hold_last  = 32'(ALERT_HOLD - 1);

  logic [1:0]       r_state;
  logic [IDXW-1:0]  r_cur;
  logic [IDXW-1:0]  r_saved;
  logic [31:0]      r_dwell;
  logic [31:0]      r_hold;
  logic [N_SRC-1:0] r_pending;
  logic [63:0]      r_disp_data;
  logic             r_strobe;

  logic [1:0]       w_state_nx;
  logic [IDXW-1:0]  w_cur_nx;
  logic [IDXW-1:0]  w_saved_nx;
  logic [31:0]      w_dwell_nx;
  logic [31:0]      w_hold_nx;
  logic [N_SRC-1:0] w_pend_nx;
  logic             w_strobe_nx;

  logic [63:0]      w_src_word [N_SRC];
  logic [N_SRC-1:0] w_cur_onehot;
  logic [N_SRC-1:0] w_low_onehot;
  logic [N_SRC-1:0] w_alert_new;
  logic [N_SRC-1:0] w_pend_eff;
  logic             w_restart;
  logic             w_pend_any;
  logic [IDXW-1:0]  w_pend_low;
  logic             w_valid_any;
  logic [IDXW-1:0]  w_valid_low;
  logic             w_nxt_cur_ok;
  logic [IDXW-1:0]  w_nxt_cur;
  logic             w_nxt_sav_ok;
  logic [IDXW-1:0]  w_nxt_sav;

  // Returns {found, index} of the lowest set bit.
  function automatic logic [IDXW:0] f_lowest(input logic [N_SRC-1:0] v);
    logic [IDXW:0] r;
    r = '0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (v[IDXW'(i)]) r = {1'b1, IDXW'(i)};
    end
    return r;
  endfunction

  // Returns {found, index}: first valid index after x (wrapping), else x itself if valid.
  function automatic logic [IDXW:0] f_next(input logic [IDXW-1:0] x, input logic [N_SRC-1:0] v);
    logic [IDXW:0] r;
    int            j;
    r = '0;
    for (int k = N_SRC - 1; k >= 1; k--) begin
      j = (int'(x) + k) % N_SRC;
      if (v[IDXW'(j)]) r = {1'b1, IDXW'(j)};
    end
    if (!r[IDXW] && v[x]) r = {1'b1, x};
    return r;
  endfunction

  genvar gi;
  generate
    for (gi = 0; gi < N_SRC; gi++) begin : g_unpack
      assign w_src_word[gi] = src_data[64*gi +: 64];
    end
  endgenerate

  // A repeat alert for the page already on screen only restarts its hold timer.
  assign w_cur_onehot = N_SRC'(1) << r_cur;
  assign w_restart    = (r_state == c_st_alert) && alert[r_cur];
  assign w_alert_new  = alert & ~((r_state == c_st_alert) ? w_cur_onehot : '0);
  assign w_pend_eff   = r_pending | w_alert_new;

  assign {w_pend_any,   w_pend_low}  = f_lowest(w_pend_eff);
  assign {w_valid_any,  w_valid_low} = f_lowest(src_valid);
  assign {w_nxt_cur_ok, w_nxt_cur}   = f_next(r_cur, src_valid);
  assign {w_nxt_sav_ok, w_nxt_sav}   = f_next(r_saved, src_valid);
  assign w_low_onehot = N_SRC'(1) << w_pend_low;

  always_comb begin
    w_state_nx  = r_state;
    w_cur_nx    = r_cur;
    w_saved_nx  = r_saved;
    w_dwell_nx  = r_dwell;
    w_hold_nx   = r_hold;
    w_pend_nx   = w_pend_eff;
    w_strobe_nx = 1'b0;
    case (r_state)
      c_st_idle: begin
        if (w_pend_any) begin
          w_state_nx  = c_st_alert;
          w_saved_nx  = r_cur;
          w_cur_nx    = w_pend_low;
          w_hold_nx   = '0;
          w_pend_nx   = w_pend_eff & ~w_low_onehot;
          w_strobe_nx = 1'b1;
        end else if (w_valid_any) begin
          w_state_nx  = c_st_show;
          w_cur_nx    = w_valid_low;
          w_dwell_nx  = '0;
          w_strobe_nx = 1'b1;
        end
      end
      c_st_show: begin
        if (w_pend_any) begin
          w_state_nx  = c_st_alert;
          w_saved_nx  = r_cur;
          w_cur_nx    = w_pend_low;
          w_hold_nx   = '0;
          w_pend_nx   = w_pend_eff & ~w_low_onehot;
          w_strobe_nx = 1'b1;
        end else if (!src_valid[r_cur]) begin
          w_dwell_nx  = '0;
          w_strobe_nx = 1'b1;
          if (w_nxt_cur_ok) w_cur_nx   = w_nxt_cur;
          else              w_state_nx = c_st_idle;
        end else if (auto_mode) begin
          if (r_dwell == c_dwell_last || next_pulse) begin
            w_dwell_nx  = '0;
            w_cur_nx    = w_nxt_cur;
            w_strobe_nx = (w_nxt_cur != r_cur);
          end else begin
            w_dwell_nx = r_dwell + 32'd1;
          end
        end else begin
          // Manual mode pins dwell at zero, so a mode toggle always restarts it.
          w_dwell_nx = '0;
          if (next_pulse) begin
            w_cur_nx    = w_nxt_cur;
            w_strobe_nx = (w_nxt_cur != r_cur);
          end
        end
      end
      c_st_alert: begin
        if (w_restart) begin
          w_hold_nx = '0;
        end else if (r_hold == c_hold_last) begin
          w_hold_nx  = '0;
          w_dwell_nx = '0;
          if (w_pend_any) begin
            w_cur_nx    = w_pend_low;
            w_pend_nx   = w_pend_eff & ~w_low_onehot;
            w_strobe_nx = 1'b1;
          end else if (src_valid[r_saved]) begin
            w_state_nx  = c_st_show;
            w_cur_nx    = r_saved;
            w_strobe_nx = (r_saved != r_cur);
          end else if (w_nxt_sav_ok) begin
            w_state_nx  = c_st_show;
            w_cur_nx    = w_nxt_sav;
            w_strobe_nx = (w_nxt_sav != r_cur);
          end else begin
            w_state_nx  = c_st_idle;
            w_strobe_nx = 1'b1;
          end
        end else begin
          w_hold_nx = r_hold + 32'd1;
        end
      end
      default: begin
        w_state_nx = c_st_idle;
      end
    endcase
  end

  always_ff @(posedge clock_27mhz or negedge reset_b) begin
    if (!reset_b) begin
      r_state     <= c_st_idle;
      r_cur       <= '0;
      r_saved     <= '0;
      r_dwell     <= '0;
      r_hold      <= '0;
      r_pending   <= '0;
      r_disp_data <= IDLE_PATTERN;
      r_strobe    <= 1'b0;
    end else begin
      r_state     <= w_state_nx;
      r_cur       <= w_cur_nx;
      r_saved     <= w_saved_nx;
      r_dwell     <= w_dwell_nx;
      r_hold      <= w_hold_nx;
      r_pending   <= w_pend_nx;
      r_disp_data <= (r_state == c_st_idle) ? IDLE_PATTERN : w_src_word[r_cur];
      r_strobe    <= w_strobe_nx;
    end
  end

  assign disp_data     = r_disp_data;
  assign disp_src      = r_cur;
  assign disp_active   = (r_state != c_st_idle);
  assign alert_active  = (r_state == c_st_alert);
  assign switch_strobe = r_strobe;

endmodule
`default_nettype wire

// File: doc/hex_display_scheduler.md
Name: hex_display_scheduler

Overview:
- Time-shares the 16-digit labkit hex display among N_SRC debug sources (radar angle/range, sonar, FSM state words, ...).
- Sits between the sources and display_16hex_labkit. Drives that driver's 64-bit data input.
- Rotates through requesting sources on a dwell timer, or steps manually on a button pulse. Pre-empts rotation with a timed alert page.

Parameters:
- N_SRC, 4, number of sources (2..8)
- IDXW, 2, index width, equal to clog2(N_SRC)
- DWELL, 27000000, cycles each source stays on screen in auto mode (1 s at 27 MHz)
- ALERT_HOLD, 54000000, cycles an alert page stays on screen
- IDLE_PATTERN, 64'h0, shown when no source is valid

Ports:
- clock_27mhz  in  1  system clock
- reset_b  in  1  asynchronous active-low reset
- src_valid  in  N_SRC  source i requests screen time (level)
- src_data  in  64*N_SRC  source i data at bits [64i+63:64i]
- alert  in  N_SRC  one-cycle pulse; source i demands immediate display
- auto_mode  in  1  1 = timed rotation, 0 = manual stepping
- next_pulse  in  1  one-cycle pulse, already debounced; manual advance
- disp_data  out  64  to the display driver data input
- disp_src  out  IDXW  index currently shown
- disp_active  out  1  a source is shown (not idle)
- alert_active  out  1  an alert page is being shown
- switch_strobe  out  1  one-cycle pulse when disp_src changes or leaves/enters idle

Behaviour:
- Reset is asynchronous, active-low, and may assert mid-operation. On reset:
  - state=IDLE, cur=0, saved=0, dwell=0, hold=0, pending=0
  - disp_data=IDLE_PATTERN, disp_src=0
  - disp_active=0, alert_active=0, switch_strobe=0
- next(x): search x+1, x+2, ... mod N_SRC, wrapping, for the first index with src_valid=1. If none is found and src_valid[x]=1, result is x. Otherwise result is none.
- pending[i] is set by alert[i]. It is cleared when that index enters ALERT.
  - Exception: an alert[i] pulse while ALERT is showing i restarts hold=0 and is not pended.
- Priority every cycle, highest first:
  1. Pending alert
  2. Loss of src_valid[cur]
  3. Dwell expiry or next_pulse
- disp_data is registered. When cur changes on edge k, disp_data carries the new source from edge k+1. Thereafter it tracks src_data[cur] live every cycle.
- IDLE:
  - disp_data=IDLE_PATTERN.
  - Any pending alert goes to ALERT.
  - Otherwise, if any src_valid: cur = lowest valid index, go to SHOW, dwell=0, strobe.
- SHOW:
  - Any pending alert: saved=cur; cur = lowest pending index; go to ALERT; hold=0; strobe.
  - Else if src_valid[cur]=0: if next(cur) exists, move there (dwell=0, strobe); else go to IDLE (strobe).
  - Else if auto_mode=1: dwell increments. At dwell==DWELL-1, dwell=0 and cur=next(cur). Strobe only if the index changed.
  - Else if auto_mode=0: dwell holds at 0. next_pulse applies the same advance.
  - Toggling auto_mode resets dwell to 0.
- ALERT:
  - Shows src_data[cur] regardless of src_valid. alert_active=1. next_pulse is ignored.
  - hold increments. At hold==ALERT_HOLD-1:
    - If another alert is pending, move to the lowest pending index, hold=0.
    - Else if src_valid[saved]=1, return to SHOW at saved, dwell=0.
    - Else if next(saved) exists, go to SHOW there.
    - Else go to IDLE.
  - Strobe on every index change.
- Simultaneous events: an alert in the same cycle as dwell expiry or next_pulse is handled by alert only; the advance is dropped. Alert pulses on several indices in one cycle are all pended and served lowest first.
- Counters are 32-bit. DWELL and ALERT_HOLD are at least 2.

Test Plan (N_SRC=4, DWELL=8, ALERT_HOLD=5, auto_mode=1 unless stated):
- Reset, then valid=4'b0000 -> disp_data=0, disp_active=0. Set valid=4'b0101 -> next edge cur=0 with strobe; one edge later disp_data=src0; after 8 cycles cur=2; after 8 more cur=0 (wrap).
- valid=4'b0100 only -> cur stays 2 across dwell expiries with no strobe. Drop valid[2] -> IDLE, disp_data=0, disp_active=0, strobe.
- auto_mode=0, valid=4'b1111 -> cur holds 0 for 50 cycles; three next_pulse -> 1, 2, 3; a fourth wraps to 0.
- Showing 1, alert[3] pulse -> cur=3, alert_active=1 for 5 cycles, then back to 1 with dwell=0. Repeat with valid[1] dropped during the alert -> resumes at next(1).
- alert=4'b1010 in the same cycle as dwell expiry -> alerts 1 then 3 (5 cycles each), no rotation step. alert[1] re-pulsed at hold=3 -> hold restarts, 1 shown 5 more cycles.
- Assert reset_b=0 mid-ALERT between clock edges -> outputs return to reset values immediately, pending cleared, and no alert page follows release.
